mem_access_unit: RTL and testbench

//  Bus initiator between the multicycle core and the word-wide data memory (combinational read, word-indexed).

---
 rtl/mem_access_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access unit: FSM states, funct3 codes, lane widths.
// Used by mem_access_unit and lsu_lane_align.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR      = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int OFF_W  = 2;
  localparam int LANE_W = 8;

  // Reserved encodings (011/110/111) have funct3[1] set, so they fall into the word class.
  function automatic logic is_word(input logic [2:0] f3);
    return f3[1];
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

  function automatic logic is_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends sub-word load data, and merges
// sub-word store data into a previously read memory word.
module lsu_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0]      rdata,
  input  logic [15:0]      wdata,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       funct3,
  output logic [31:0]      load_data,
  output logic [31:0]      merge_data
);

  logic [LANE_W-1:0] byte_v;
  logic [15:0]       half_v;
  logic [4:0]        bit_off;

  assign bit_off = {off, 3'b000};

  always_comb begin
    byte_v     = rdata[bit_off +: LANE_W];
    half_v     = off[1] ? rdata[31:16] : rdata[15:0];
    load_data  = rdata;
    merge_data = rdata;
    if (is_word(funct3)) begin
      load_data  = rdata;
      merge_data = rdata;
    end else if (is_half(funct3)) begin
      load_data = funct3[2] ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
      if (off[1]) merge_data[31:16] = wdata;
      else        merge_data[15:0]  = wdata;
    end else begin
      load_data = funct3[2] ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
      merge_data[bit_off +: LANE_W] = wdata[7:0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus initiator: one request at a time, sub-word stores by read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned or illegal requests complete at once with rsp_error.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for a request, req_ready high
// ST_RD_WAIT | address held, counting down until mem_rdata is sampled
// ST_WR      | single-cycle memory write
// ST_DONE    | rsp_valid pulse, then back to idle
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we
);

  localparam int CNT_W = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT + 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [OFF_W-1:0]  off_q;
  logic [15:0]       wdata_q;
  logic              accept, trap_req, rd_last;
  logic              mem_we_q, rsp_valid_q;
  logic [31:0]       load_data, merge_data;

  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rd_last   = (cnt == CNT_W'(1));

`ifdef MISALIGN_TRAP_EN
  assign trap_req = !is_legal(req_funct3)
                 || (is_word(req_funct3) && (req_addr[1:0] != 2'b00))
                 || (is_half(req_funct3) && req_addr[0]);
`else
  assign trap_req = 1'b0;
`endif

  // Gate the registered strobes so an abort via reset can never leak a write or response.
  assign mem_we    = mem_we_q && !reset;
  assign rsp_valid = rsp_valid_q && !reset;

  lsu_lane_align u_lane (
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .off        (off_q),
    .funct3     (funct3_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (trap_req)                               next_state = ST_DONE;
          else if (req_write && is_word(req_funct3))  next_state = ST_WR;
          else                                        next_state = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: if (rd_last) next_state = write_q ? ST_WR : ST_DONE;
      ST_WR:      next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= '0;
      wdata_q     <= 16'h0000;
      mem_address <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_error   <= 1'b0;
    end else begin
      mem_we_q    <= (next_state == ST_WR);
      rsp_valid_q <= (next_state == ST_DONE);
      rsp_error   <= accept && trap_req;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            cnt       <= CNT_W'(READ_WAIT);
            rsp_rdata <= 32'h0;
            if (!trap_req) mem_address <= {req_addr[31:2], 2'b00};
            if (req_write && is_word(req_funct3) && !trap_req) mem_wdata <= req_wdata;
          end
        end
        ST_RD_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (rd_last) begin
            if (write_q) mem_wdata <= merge_data;
            else         rsp_rdata <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-level reference model.
// Honours MISALIGN_TRAP_EN when the macro is defined for the build.
module tb_mem_access_unit;

  localparam int READ_WAIT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error, mem_we;
  logic [31:0] rsp_rdata, mem_address, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.READ_WAIT(READ_WAIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_we      (mem_we)
  );

  // Bench memory: 64 words, written by the DUT or by the bench poke port.
  logic [31:0] dmem [0:63];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_data;

  assign mem_rdata = dmem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_we)  dmem[mem_address[7:2]] <= mem_wdata;
    if (poke_en) dmem[poke_idx] <= poke_data;
  end

  logic [31:0] ref_mem [0:63];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    poke_en   = 1'b1;
    poke_idx  = idx;
    poke_data = data;
    @(posedge clk);
    #1 poke_en = 1'b0;
    ref_mem[idx] = data;
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input int f3, input logic [31:0] addr);
    logic [31:0] v;
    int sh;
    case (f3)
      0, 4: begin
        sh = 8 * int'(addr[1:0]);
        v  = (word >> sh) & 32'hFF;
        if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      1, 5: begin
        sh = 16 * int'(addr[1]);
        v  = (word >> sh) & 32'hFFFF;
        if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input int f3, input logic [31:0] addr);
    logic [31:0] mask;
    int sh;
    case (f3)
      0: begin
        sh   = 8 * int'(addr[1:0]);
        mask = 32'hFF << sh;
        return (old & ~mask) | ((wd & 32'hFF) << sh);
      end
      1: begin
        sh   = 16 * int'(addr[1]);
        mask = 32'hFFFF << sh;
        return (old & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  function automatic bit model_trap(input int f3, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (f3 == 2 && addr[1:0] != 2'b00) return 1'b1;
    if ((f3 == 1 || f3 == 5) && addr[0]) return 1'b1;
    return 1'b0;
`else
    return (f3 < 0) && (addr == 32'h0);
`endif
  endfunction

  task automatic do_req(input string name, input bit wr, input int f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int idx, exp_cyc, k, we_cnt, we_cyc, rsp_cyc;
    bit trap, is_w, got;
    logic [31:0] old, exp_rdata, exp_new, got_rdata, got_addr;
    logic got_err;
    idx  = int'(addr[7:2]);
    old  = ref_mem[idx];
    trap = model_trap(f3, addr);
    is_w = (f3 == 2 || f3 == 3 || f3 == 6 || f3 == 7);
    if (trap)            exp_cyc = 1;
    else if (wr && is_w) exp_cyc = 2;
    else if (wr)         exp_cyc = READ_WAIT + 2;
    else                 exp_cyc = READ_WAIT + 1;
    exp_rdata = (trap || wr) ? 32'h0 : model_load(old, f3, addr);
    exp_new   = (wr && !trap) ? model_store(old, wd, f3, addr) : old;

    check({name, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = 3'(f3);
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;

    k = 0; we_cnt = 0; we_cyc = 0; rsp_cyc = 0; got = 1'b0;
    got_rdata = 32'h0; got_addr = 32'h0; got_err = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (mem_we) begin
        we_cnt++;
        we_cyc = k;
        check({name, ".mem_wdata"}, mem_wdata, exp_new);
        check({name, ".we_addr"}, mem_address, {addr[31:2], 2'b00});
      end
      if (rsp_valid) begin
        got       = 1'b1;
        rsp_cyc   = k;
        got_rdata = rsp_rdata;
        got_err   = rsp_error;
        got_addr  = mem_address;
        check({name, ".ready_in_done"}, {31'b0, req_ready}, 32'd0);
      end
    end
    if (!got) begin
      check({name, ".rsp_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, ".latency"}, 32'(rsp_cyc), 32'(exp_cyc));
      check({name, ".rdata"}, got_rdata, exp_rdata);
      check({name, ".error"}, {31'b0, got_err}, {31'b0, trap});
      check({name, ".we_count"}, 32'(we_cnt), (wr && !trap) ? 32'd1 : 32'd0);
      if (wr && !trap) check({name, ".we_cycle"}, 32'(we_cyc), 32'(exp_cyc - 1));
      if (!trap) check({name, ".address"}, got_addr, {addr[31:2], 2'b00});
    end
    @(negedge clk);
    check({name, ".rsp_pulse"}, {31'b0, rsp_valid}, 32'd0);
    check({name, ".ready_after"}, {31'b0, req_ready}, 32'd1);
    check({name, ".mem_word"}, dmem[idx], exp_new);
    ref_mem[idx] = exp_new;
  endtask

  initial begin
    int load_f3 [8] = '{0, 1, 2, 4, 5, 3, 6, 7};
    bit wr;
    int f3;
    logic [31:0] a, wd;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; poke_en = 1'b0; poke_idx = 6'd0; poke_data = 32'h0;
    @(negedge clk); @(negedge clk);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'h0);
    check("rst.rsp_error", {31'b0, rsp_error}, 32'd0);
    check("rst.mem_address", mem_address, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.mem_we", {31'b0, mem_we}, 32'd0);
    check("rst.req_ready", {31'b0, req_ready}, 32'd0);

    for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
    check("rst.mem_we_end", {31'b0, mem_we}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    poke(6'h04, 32'h8070_F0A5);
    do_req("t1_lw", 1'b0, 2, 32'h10, 32'h0);
    do_req("t2_lb", 1'b0, 0, 32'h13, 32'h0);
    check("t2_lb.value", rsp_rdata, 32'hFFFF_FF80);
    do_req("t2_lbu", 1'b0, 4, 32'h13, 32'h0);
    check("t2_lbu.value", rsp_rdata, 32'h0000_0080);
    do_req("t2_lhu", 1'b0, 5, 32'h12, 32'h0);
    check("t2_lhu.value", rsp_rdata, 32'h0000_8070);
    poke(6'h04, 32'h1122_3344);
    do_req("t3_sb", 1'b1, 0, 32'h11, 32'h0000_00AB);
    check("t3_sb.word", dmem[4], 32'h1122_AB44);
    do_req("t4_sw", 1'b1, 2, 32'h20, 32'hDEAD_BEEF);
    check("t4_sw.word", dmem[8], 32'hDEAD_BEEF);
    do_req("t5_lw_mis", 1'b0, 2, 32'h22, 32'h0);

    // Reset while a halfword store is still reading.
    poke(6'h05, 32'hCAFE_F00D);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h16; req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6.mem_we", {31'b0, mem_we}, 32'd0);
      check("t6.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("t6.req_ready", {31'b0, req_ready}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("t6.ready_after", {31'b0, req_ready}, 32'd1);
    check("t6.mem_word", dmem[5], 32'hCAFE_F00D);

    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = wr ? int'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 7)];
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
      do_req(wr ? "rnd_st" : "rnd_ld", wr, f3, a, wd);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
